pattern_detector_p: RTL
=======================

# pattern_detector_p

Parametrised, programmable serial pattern detector; next generation of the team's fixed single-bit overlapping sequence detector. Accepts one SYM_W-bit symbol per cycle when valid_i is high and compares the last PAT_LEN accepted symbols against a runtime-loadable, per-position-maskable pattern. Emits a registered one-cycle match pulse and keeps a saturating match count. Overlapping and non-overlapping detection are both supported. Sits between a symbol source and the match-handling logic.

## Interface
- SYM_W, 1: bits per symbol.
- PAT_LEN, 5: pattern length in symbols, ≥2.
- CNT_W, 8: match counter width.
- RST_PAT, 5'b10110: reset pattern. Position k is bits [k*SYM_W +: SYM_W]; position 0 is the oldest symbol. Default is B,C,C,B,C with B=0, C=1.
- RST_MASK, all ones: reset per-position compare enable, PAT_LEN bits.
- RST_OVL, 1: reset mode; 1 = overlapping, 0 = non-overlapping.
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  d_i is a valid symbol this cycle.
- d_i  in  SYM_W  input symbol.
- cfg_we_i  in  1  load cfg_pat_i, cfg_mask_i and cfg_ovl_i.
- cfg_pat_i  in  PAT_LEN*SYM_W  new pattern.
- cfg_mask_i  in  PAT_LEN  1 = position compared, 0 = don't care.
- cfg_ovl_i  in  1  new overlap mode.
- cnt_clr_i  in  1  clear match counter.
- pattern_o  out  1  one-cycle match pulse.
- match_cnt_o  out  CNT_W  saturating match count.

## Operation
- State:
  - hist: PAT_LEN-1 symbols, shift register.
  - fill: 0..PAT_LEN-1, count of accepted symbols held.
  - pat, mask, ovl: configuration registers.
  - pattern_o and match_cnt_o: registered outputs.
- Accept: valid_i=1 and cfg_we_i=0.
  - hist shifts, d_i enters as newest.
  - fill increments, saturating at PAT_LEN-1.
- Hit: on an accept with fill==PAT_LEN-1, window {hist, d_i} equals pat at every position where mask=1.
  - mask all-zero: every accept with full fill is a hit.
- On a hit:
  - pattern_o<=1 next cycle.
  - match_cnt_o increments, saturating at all ones.
  - ovl=0: fill<=0, so the next hit needs PAT_LEN fresh symbols.
  - ovl=1: fill unchanged, so overlapping hits are allowed.
- No accept or no hit: pattern_o<=0.
- valid_i=0: hist, fill and count hold. Bubbles are invisible to matching.
- cfg_we_i=1 has priority over valid_i.
  - Loads pat, mask and ovl; fill<=0; pattern_o<=0.
  - The symbol presented that cycle is dropped.
  - match_cnt_o is unaffected.
- cnt_clr_i=1: match_cnt_o<=0. If a hit occurs the same cycle, the clear wins (count 0) and pattern_o still pulses.
- Reset (any time, asynchronous): pat=RST_PAT, mask=RST_MASK, ovl=RST_OVL, hist=0, fill=0, pattern_o=0, match_cnt_o=0. A partial match in progress is discarded.

## Timing
- Latency: pattern_o is high for exactly the cycle after the edge that accepts the completing symbol.
- Back-to-back hits (ovl=1, periodic pattern) give consecutive high cycles; each counts.
- match_cnt_o updates on the same edge as pattern_o rises.
- New configuration applies to the first symbol accepted after the cfg_we_i edge.
- Throughput: one symbol per cycle. No backpressure; no ready output.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package pattern_det_pkg:
  - symbol constants B and C;
  - default 5-symbol pattern and mask;
  - mode encoding OVL/NOVL.
- Sub-module pd_window_cmp: combinational masked compare of a PAT_LEN window against pattern and mask; outputs hit.
- Top level holds the history, fill counter, config registers, output and counter logic.

## Test plan
- Defaults, ovl=1, stream 0,1,1,0,1,1,0,1 with valid_i constant → pulses after symbols 5 and 8; match_cnt_o=2.
- Same stream after config load with cfg_ovl_i=0 → single pulse after symbol 5; match_cnt_o=1.
- Default stream with valid_i low for 3 cycles between every symbol → same pulses, each one cycle after its completing symbol; count 2.
- SYM_W=4, PAT_LEN=3, pattern A,x,5 with mask 3'b101; stream A,7,5,A,0,5 → pulses after symbols 3 and 6.
- cfg_we_i asserted on the cycle of symbol 5 of 0,1,1,0,1 → no pulse; fill=0; the next 5 matching symbols pulse once.
- Asynchronous reset after 0,1,1,0 → outputs 0 immediately; a following 1 gives no pulse.
- CNT_W=2, 5 hits → count stops at 3.
- cnt_clr_i coincident with a hit → count 0, pulse present.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   B, C      : the two symbol values of the legacy single-bit detector
//   DEF_PAT   : legacy 5-symbol pattern B,C,C,B,C (position 0 = oldest, in bit 0)
//   DEF_MASK  : compare every position of the legacy pattern
//   ovl_mode_e: overlapping (OVL) / non-overlapping (NOVL) detection
package pattern_det_pkg;

  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  localparam int         DEF_PAT_LEN = 5;
  localparam logic [4:0] DEF_PAT     = {C, B, C, C, B};
  localparam logic [4:0] DEF_MASK    = 5'b11111;

  typedef enum logic {
    NOVL = 1'b0,
    OVL  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/pd_window_cmp.sv
// Combinational masked compare of a PAT_LEN-symbol window against a pattern.
//   window : PAT_LEN*SYM_W  candidate symbols, position k at [k*SYM_W +: SYM_W]
//   pat    : PAT_LEN*SYM_W  reference pattern, same layout
//   mask   : PAT_LEN        1 = position compared, 0 = don't care
//   hit    : 1              every compared position matches (all-zero mask -> 1)
module pd_window_cmp #(
  parameter int SYM_W   = 1,
  parameter int PAT_LEN = 5
) (
  input  logic [PAT_LEN*SYM_W-1:0] window,
  input  logic [PAT_LEN*SYM_W-1:0] pat,
  input  logic [PAT_LEN-1:0]       mask,
  output logic                     hit
);

  always_comb begin
    // NOTE: default assignment first so every path drives hit; no latch.
    hit = 1'b1;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (mask[k] && (window[k*SYM_W +: SYM_W] != pat[k*SYM_W +: SYM_W])) begin
        hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pattern_detector_p.sv
// Programmable serial pattern detector.
// Compares the last PAT_LEN accepted symbols against a runtime-loadable,
// per-position-maskable pattern; emits a registered one-cycle match pulse and
// keeps a saturating match count.
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   valid_i     : d_i carries a symbol this cycle
//   d_i         : input symbol (SYM_W bits)
//   cfg_we_i    : load cfg_pat_i / cfg_mask_i / cfg_ovl_i (drops this cycle's symbol)
//   cfg_pat_i   : new pattern, position 0 = oldest symbol
//   cfg_mask_i  : new per-position compare enable
//   cfg_ovl_i   : new mode, 1 = overlapping
//   cnt_clr_i   : clear match counter (wins over a same-cycle hit)
//   pattern_o   : one-cycle match pulse
//   match_cnt_o : saturating match count
module pattern_detector_p
  import pattern_det_pkg::*;
#(
  parameter int                         SYM_W    = 1,
  parameter int                         PAT_LEN  = 5,
  parameter int                         CNT_W    = 8,
  parameter logic [PAT_LEN*SYM_W-1:0]   RST_PAT  = DEF_PAT,
  parameter logic [PAT_LEN-1:0]         RST_MASK = '1,
  parameter logic                       RST_OVL  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [SYM_W-1:0]         d_i,
  input  logic                     cfg_we_i,
  input  logic [PAT_LEN*SYM_W-1:0] cfg_pat_i,
  input  logic [PAT_LEN-1:0]       cfg_mask_i,
  input  logic                     cfg_ovl_i,
  input  logic                     cnt_clr_i,
  output logic                     pattern_o,
  output logic [CNT_W-1:0]         match_cnt_o
);

  localparam int                HIST_W    = (PAT_LEN - 1) * SYM_W;
  localparam int                FILL_W    = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [HIST_W-1:0]        hist;
  logic [FILL_W-1:0]        fill;
  logic [PAT_LEN*SYM_W-1:0] pat;
  logic [PAT_LEN-1:0]       mask;
  ovl_mode_e                ovl;

  logic [PAT_LEN*SYM_W-1:0] window;
  logic                     win_hit;
  logic                     accept;
  logic                     hit;

  // Newest symbol sits at the top position, oldest history symbol at position 0.
  assign window = {d_i, hist};
  assign accept = valid_i && !cfg_we_i;
  assign hit    = accept && (fill == FILL_FULL) && win_hit;

  pd_window_cmp #(
    .SYM_W  (SYM_W),
    .PAT_LEN(PAT_LEN)
  ) u_cmp (
    .window(window),
    .pat   (pat),
    .mask  (mask),
    .hit   (win_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat       <= RST_PAT;
      mask      <= RST_MASK;
      ovl       <= ovl_mode_e'(RST_OVL);
      // NOTE: the history is a small shift register, not a RAM, so it is reset
      // along with the rest of the state; fill=0 already hides stale content.
      hist      <= '0;
      fill      <= '0;
      pattern_o <= 1'b0;
    end else if (cfg_we_i) begin
      // Configuration wins over valid_i: symbol dropped, partial match discarded.
      pat       <= cfg_pat_i;
      mask      <= cfg_mask_i;
      ovl       <= ovl_mode_e'(cfg_ovl_i);
      fill      <= '0;
      pattern_o <= 1'b0;
    end else if (valid_i) begin
      hist      <= window[PAT_LEN*SYM_W-1:SYM_W];
      pattern_o <= hit;
      if (hit) begin
        // Non-overlapping mode needs PAT_LEN fresh symbols before the next hit.
        if (ovl == NOVL) fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end else begin
      // Bubble: history and fill hold, so idle cycles are invisible to matching.
      pattern_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      match_cnt_o <= '0;
    end else if (hit && (match_cnt_o != {CNT_W{1'b1}})) begin
      match_cnt_o <= match_cnt_o + CNT_W'(1);
    end
  end

endmodule
